// File: rtl/conv_fprop1_mul_share_arb.sv
// Round-robin share of one combinational multiplier among NREQ requesters.
// Two-stage pipeline: S1 drives the multiplier operands, S2 holds the product for the response port.
module conv_fprop1_mul_share_arb #(
    parameter int NREQ   = 4,
    parameter int DIN0_W = 11,
    parameter int DIN1_W = 6,
    parameter int DOUT_W = 16,
    parameter int ID_W   = 2
) (
    input  logic                     ap_clk,
    input  logic                     ap_rst_n,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*DIN0_W-1:0]   req_din0,
    input  logic [NREQ*DIN1_W-1:0]   req_din1,
    output logic [DIN0_W-1:0]        mul_din0,
    output logic [DIN1_W-1:0]        mul_din1,
    input  logic [DOUT_W-1:0]        mul_dout,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [DOUT_W-1:0]        rsp_dout
);

    logic              s1_valid;
    logic [ID_W-1:0]   s1_id;
    logic [DIN0_W-1:0] s1_a;
    logic [DIN1_W-1:0] s1_b;
    logic              s2_valid;
    logic [ID_W-1:0]   s2_id;
    logic [DOUT_W-1:0] s2_prod;
    logic [ID_W-1:0]   rr_ptr;

    logic              s2_adv;
    logic              s1_adv;
    logic              grant_found;
    logic [ID_W-1:0]   grant_id;
    logic [DIN0_W-1:0] grant_a;
    logic [DIN1_W-1:0] grant_b;

    assign s2_adv = !s2_valid || rsp_ready;
    assign s1_adv = !s1_valid || s2_adv;

    // Rotating priority: requesters above rr_ptr first, then wrap to those at or below it.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!grant_found && req_valid[i] && (ID_W'(i) > rr_ptr)) begin
                grant_found = 1'b1;
                grant_id    = ID_W'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!grant_found && req_valid[i] && (ID_W'(i) <= rr_ptr)) begin
                grant_found = 1'b1;
                grant_id    = ID_W'(i);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        grant_a   = '0;
        grant_b   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_found && (grant_id == ID_W'(i))) begin
                req_ready[i] = s1_adv;
                grant_a      = req_din0[i*DIN0_W +: DIN0_W];
                grant_b      = req_din1[i*DIN1_W +: DIN1_W];
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every stage samples pre-edge values.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            s1_valid <= 1'b0;
            s1_id    <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
            s2_valid <= 1'b0;
            s2_id    <= '0;
            s2_prod  <= '0;
            rr_ptr   <= ID_W'(NREQ - 1);
        end else begin
            if (s2_adv) begin
                s2_valid <= s1_valid;
                s2_id    <= s1_id;
                s2_prod  <= mul_dout;
            end
            if (s1_adv) begin
                s1_valid <= grant_found;
                if (grant_found) begin
                    s1_id  <= grant_id;
                    s1_a   <= grant_a;
                    s1_b   <= grant_b;
                    rr_ptr <= grant_id;
                end
            end
        end
    end

    assign mul_din0  = s1_a;
    assign mul_din1  = s1_b;
    assign rsp_valid = s2_valid;
    assign rsp_id    = s2_id;
    assign rsp_dout  = s2_prod;

endmodule
